// File: rtl/bios_word_sink.sv
// bios_word_sink: pulls BIOS words in fixed bursts into a 64x16 FIFO and drains them to a memory write port
// Ports: clk_sdr/reset (async, active-high); load_start restarts address, word count and checksum;
// bios_wr/bios_req/bios_din form the loader handshake (data valid the cycle after bios_req);
// mem_we/mem_addr/mem_din/mem_ack form the memory write port; busy flags pending work;
// words counts acknowledged writes; checksum exists only with BIOS_SINK_CHECKSUM_EN defined.
module bios_word_sink #(
  parameter int BASE_ADDR = 0,
  parameter int ADDR_W = 20,
  parameter int BURST_LEN = 32
) (
  input  logic              clk_sdr,
  input  logic              reset,
  input  logic              load_start,
  input  logic              bios_wr,
  output logic              bios_req,
  input  logic [15:0]       bios_din,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_din,
  input  logic              mem_ack,
  output logic              busy,
  output logic [ADDR_W-1:0] words
`ifdef BIOS_SINK_CHECKSUM_EN
  ,
  output logic [15:0]       checksum
`endif
);
  typedef enum logic [1:0] {IDLE, PULL, TAIL, RELEASE} state_t;
  state_t state;
  logic [15:0] fifo [64];
  logic [6:0] wptr, rptr, used;
  logic [5:0] beat;
  logic cap, armed, pend, full, empty, go, push, pop, ld_ok;
  assign used = wptr - rptr;
  assign full = used == 7'd64;
  assign empty = used == 7'd0;
  // armed delays the first burst to the second edge after reset
  assign go = state == IDLE && armed && bios_wr && (7'd64 - used) >= 7'(BURST_LEN);
  assign push = cap && !full;
  assign pop = mem_we && mem_ack;
  assign ld_ok = state == IDLE && empty && !mem_we;
  assign busy = state != IDLE || !empty || mem_we;
  always_ff @(posedge clk_sdr)
    if (push) fifo[wptr[5:0]] <= bios_din;
  always_ff @(posedge clk_sdr or posedge reset)
    if (reset) begin
      state <= IDLE;
      wptr <= '0;
      rptr <= '0;
      beat <= '0;
      cap <= 1'b0;
      armed <= 1'b0;
      pend <= 1'b0;
      bios_req <= 1'b0;
      mem_we <= 1'b0;
      mem_din <= '0;
      mem_addr <= ADDR_W'(BASE_ADDR);
      words <= '0;
`ifdef BIOS_SINK_CHECKSUM_EN
      checksum <= '0;
`endif
    end else begin
      armed <= 1'b1;
      cap <= bios_req;
      if (push) wptr <= wptr + 7'd1;
      case (state)
        IDLE: if (go) begin
          state <= PULL;
          bios_req <= 1'b1;
          beat <= '0;
        end
        PULL: begin
          beat <= beat + 6'd1;
          if (beat == 6'(BURST_LEN - 1)) begin
            bios_req <= 1'b0;
            state <= TAIL;
          end
        end
        TAIL: state <= RELEASE;
        RELEASE: if (!bios_wr) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (pop) begin
        mem_we <= 1'b0;
        rptr <= rptr + 7'd1;
        mem_addr <= mem_addr + ADDR_W'(1);
        words <= words + ADDR_W'(1);
`ifdef BIOS_SINK_CHECKSUM_EN
        checksum <= checksum + mem_din;
`endif
      end else if (!mem_we && !empty) begin
        mem_we <= 1'b1;
        mem_din <= fifo[rptr[5:0]];
      end
      // a restart is only applied once everything queued has been written
      if (ld_ok && (load_start || pend)) begin
        mem_addr <= ADDR_W'(BASE_ADDR);
        words <= '0;
        pend <= 1'b0;
`ifdef BIOS_SINK_CHECKSUM_EN
        checksum <= '0;
`endif
      end else if (load_start) pend <= 1'b1;
    end
endmodule

// File: doc/bios_word_sink.md
BIOS_WORD_SINK -- requirements
Module: bios_word_sink

Interface
REQ-001 Parameter BASE_ADDR, default 0: memory word address written by the first word after load_start.
REQ-002 Parameter ADDR_W, default 20: width of mem_addr.
REQ-003 Parameter BURST_LEN, default 32: words pulled per bios_wr grant; fixed power of two no larger than 32.
REQ-004 Port list, one line each:
  clk_sdr  in  1  sole clock; all logic on its rising edge.
  reset  in  1  asynchronous, active-high.
  load_start  in  1  one-cycle pulse; restarts the address counter (and checksum).
  bios_wr  in  1  high = loader holds a full block ready.
  bios_req  out  1  high = pull one word this cycle.
  bios_din  in  16  word, valid the cycle after each bios_req-high cycle.
  mem_we  out  1  write request to the memory port.
  mem_addr  out  ADDR_W  word address.
  mem_din  out  16  write data.
  mem_ack  in  1  write accepted on any edge where mem_we and mem_ack are both high.
  busy  out  1  high while a burst or FIFO drain is pending.
  words  out  ADDR_W  count of words acknowledged since load_start.
  checksum  out  16  present only with BIOS_SINK_CHECKSUM_EN.

Function
REQ-005 Internal FIFO: 64 x 16, with binary read/write pointers of 7 bits; full/empty are decided from the pointer difference.
REQ-006 States: IDLE, PULL, TAIL, RELEASE.
REQ-007 IDLE->PULL when bios_wr=1 and FIFO free space >= BURST_LEN; no other condition starts a burst.
REQ-008 PULL: bios_req=1 for exactly BURST_LEN consecutive cycles, then -> TAIL; bios_req never gaps inside a burst.
REQ-009 Capture: bios_din written into the FIFO on every cycle whose previous cycle had bios_req=1; exactly BURST_LEN writes per burst.
REQ-010 TAIL: one cycle, bios_req=0, captures the last word, then -> RELEASE.
REQ-011 RELEASE: bios_req=0; -> IDLE once bios_wr is sampled 0. This prevents double-pulling a block while the loader is still clearing bios_wr.
REQ-012 Drain: when the FIFO is non-empty and mem_we=0, the head word is presented on mem_din and mem_addr, with mem_we=1.
REQ-013 mem_we, mem_addr and mem_din are held stable until mem_ack. On the ack edge:
  - pop the FIFO;
  - mem_addr+1 (wraps modulo 2^ADDR_W);
  - words+1 (wraps).
  The next word may be presented the following cycle.
REQ-014 A FIFO write and a pop on the same edge both take effect; the occupancy is unchanged.
REQ-015 FIFO overflow is impossible by REQ-007. A write while full is dropped and is a verification failure.
REQ-016 busy = (state != IDLE) | FIFO non-empty | mem_we.
REQ-017 load_start while IDLE with an empty FIFO and mem_we=0: mem_addr <= BASE_ADDR, words <= 0.
REQ-018 load_start at any other time is held pending and applied on the first cycle where the REQ-017 condition holds.
REQ-019 The block ignores bios_din whenever the capture condition of REQ-009 is false.

Reset
REQ-020 reset asynchronously forces the following; it takes effect immediately, including mid-burst:
  - state=IDLE, FIFO empty;
  - bios_req=0, mem_we=0, mem_din=0;
  - mem_addr=BASE_ADDR, words=0, checksum=0;
  - pending load_start cleared.
REQ-021 After reset deasserts, the first bios_req occurs no earlier than the second rising edge.

Configuration
REQ-022 With macro BIOS_SINK_CHECKSUM_EN defined:
  - port checksum exists;
  - checksum += mem_din (modulo 2^16) on each ack edge;
  - checksum is cleared with words per REQ-017 and REQ-018.
REQ-023 Without BIOS_SINK_CHECKSUM_EN: no checksum port and no checksum logic; all other behaviour is identical.

Verification
REQ-024 reset, then load_start, then bios_wr=1 with words 0x0001..0x0020 and mem_ack tied 1 -> exactly 32 bios_req cycles; writes at addresses 0..31 with data 0x0001..0x0020; words=32; checksum=0x0210.
REQ-025 bios_wr held high for 5 cycles after bios_req falls -> no second burst until bios_wr is sampled 0.
REQ-026 mem_ack=0 throughout, 3 blocks offered -> 2 bursts accepted (64 words); the third bios_req is withheld. After 32 acks the third burst starts.
REQ-027 mem_ack toggling 1-in-3 cycles -> mem_addr and mem_din stay stable while unacked; there are no duplicate or skipped addresses.
REQ-028 reset asserted on the 10th bios_req cycle -> bios_req=0 and mem_we=0 in the same cycle; busy=0; mem_addr=BASE_ADDR.
REQ-029 load_start pulsed mid-drain with 20 words queued -> all 20 are written at consecutive addresses; then mem_addr=BASE_ADDR and words=0.
